track_para_loader: RTL and testbench



---
 rtl/track_para_pkg.sv | 23 ++
 rtl/track_para_tap_ram.sv | 37 +++
 rtl/track_para_loader.sv | 171 +++++++++++++++++
 tb/tb_track_para_loader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/track_para_pkg.sv
// Shared definitions for the track-parameter burst interface: loader state
// encodings, error codes and default geometry.
package track_para_pkg;

    localparam int TAP_NUM_DEF    = 128;
    localparam int ADDR_W_DEF     = 7;
    localparam int FLUSH_IDLE_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_FLUSH  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_SHORT    = 2'd1,
        ERR_OVERFLOW = 2'd2
    } err_e;

endpackage

// File: rtl/track_para_tap_ram.sv
// Two-bank coefficient store: simple dual-port RAM with synchronous write and
// a registered read port (one-cycle latency).
module track_para_tap_ram #(
    parameter int ADDR_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W:0]   wr_addr_i,
    input  logic [31:0]       wr_data_i,
    input  logic [ADDR_W:0]   rd_addr_i,
    output logic [31:0]       rd_data_o
);

    localparam int DEPTH = 2 ** (ADDR_W + 1);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= 32'd0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/track_para_loader.sv
// Drains track-parameter bursts into the shadow coefficient bank, validates the
// burst length against the burst-end strobe and swaps banks on success.
module track_para_loader
    import track_para_pkg::*;
#(
    parameter int TAP_NUM    = TAP_NUM_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FLUSH_IDLE = FLUSH_IDLE_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_en_i,
    output logic              track_para_ren_o,
    input  logic              track_para_vld_i,
    input  logic [31:0]       track_para_data_i,
    input  logic              track_para_burst_end_i,
    input  logic [ADDR_W-1:0] tap_rd_addr_i,
    output logic [31:0]       tap_rd_data_o,
    output logic              tap_valid_o,
    output logic              tap_bank_o,
    output logic              tap_update_o,
    output logic              load_busy_o,
    output logic              load_err_o,
    output logic [1:0]        err_code_o,
    output logic [15:0]       commit_cnt_o,
    output logic [2:0]        dbg_state_o
);

    localparam int IDLE_W = $clog2(FLUSH_IDLE + 1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(TAP_NUM);
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(FLUSH_IDLE);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
    logic                bank_q, bank_d;
    logic                valid_q, valid_d;
    logic                update_q, update_d;
    logic                load_err_q, load_err_d;
    err_e                err_code_q, err_code_d;
    logic [15:0]         commit_cnt_q, commit_cnt_d;
    logic                be_seen_q, be_seen_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                ren_q;
    logic                wr_en;
    logic [ADDR_W:0]     cnt_next;

    assign cnt_next = wr_cnt_q + (ADDR_W + 1)'(track_para_vld_i);

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        bank_d       = bank_q;
        valid_d      = valid_q;
        update_d     = 1'b0;
        load_err_d   = 1'b0;
        err_code_d   = err_code_q;
        commit_cnt_d = commit_cnt_q;
        be_seen_d    = be_seen_q;
        idle_cnt_d   = idle_cnt_q;
        wr_en        = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                wr_en = track_para_vld_i;
                if (track_para_vld_i) begin
                    wr_cnt_d = cnt_next;
                end
                if (cnt_next == FULL_CNT) begin
                    state_d = track_para_burst_end_i ? ST_COMMIT : ST_DRAIN;
                end else if (track_para_burst_end_i && cnt_next != '0) begin
                    // Burst ended before the bank was full.
                    state_d    = ST_FLUSH;
                    err_code_d = ERR_SHORT;
                    load_err_d = 1'b1;
                    be_seen_d  = 1'b1;
                    idle_cnt_d = '0;
                end else if (track_para_vld_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (track_para_vld_i) begin
                    state_d    = ST_FLUSH;
                    err_code_d = ERR_OVERFLOW;
                    load_err_d = 1'b1;
                    be_seen_d  = track_para_burst_end_i;
                    idle_cnt_d = '0;
                end else if (track_para_burst_end_i) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                bank_d       = ~bank_q;
                update_d     = 1'b1;
                valid_d      = 1'b1;
                commit_cnt_d = commit_cnt_q + 16'd1;
                err_code_d   = ERR_NONE;
                wr_cnt_d     = '0;
                state_d      = ST_IDLE;
            end
            ST_FLUSH: begin
                be_seen_d = be_seen_q | track_para_burst_end_i;
                if (track_para_vld_i) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != IDLE_LIM) begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
                if (be_seen_d && idle_cnt_d == IDLE_LIM) begin
                    state_d   = ST_IDLE;
                    wr_cnt_d  = '0;
                    be_seen_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= '0;
            bank_q       <= 1'b0;
            valid_q      <= 1'b0;
            update_q     <= 1'b0;
            load_err_q   <= 1'b0;
            err_code_q   <= ERR_NONE;
            commit_cnt_q <= 16'd0;
            be_seen_q    <= 1'b0;
            idle_cnt_q   <= '0;
            ren_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            bank_q       <= bank_d;
            valid_q      <= valid_d;
            update_q     <= update_d;
            load_err_q   <= load_err_d;
            err_code_q   <= err_code_d;
            commit_cnt_q <= commit_cnt_d;
            be_seen_q    <= be_seen_d;
            idle_cnt_q   <= idle_cnt_d;
            ren_q        <= load_en_i && (state_d != ST_COMMIT);
        end
    end

    // Writes target the shadow bank, reads the active one, so they never collide.
    track_para_tap_ram #(
        .ADDR_W (ADDR_W)
    ) u_tap_ram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en),
        .wr_addr_i ({~bank_q, wr_cnt_q[ADDR_W-1:0]}),
        .wr_data_i (track_para_data_i),
        .rd_addr_i ({bank_q, tap_rd_addr_i}),
        .rd_data_o (tap_rd_data_o)
    );

    assign track_para_ren_o = ren_q;
    assign tap_valid_o      = valid_q;
    assign tap_bank_o       = bank_q;
    assign tap_update_o     = update_q;
    assign load_busy_o      = (state_q != ST_IDLE);
    assign load_err_o       = load_err_q;
    assign err_code_o       = err_code_q;
    assign commit_cnt_o     = commit_cnt_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_track_para_loader.sv
// Bench for track_para_loader: directed burst table, hand-written corner
// sequences and random bursts checked against a burst-level reference model.
module tb_track_para_loader;
    import track_para_pkg::*;

    localparam int TAP_NUM = 128;
    localparam int ADDR_W  = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_en = 1'b0;
    logic              ren;
    logic              vld = 1'b0;
    logic [31:0]       data = 32'd0;
    logic              be = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [31:0]       rd_data;
    logic              tap_valid, tap_bank, tap_update, busy, load_err;
    logic [1:0]        err_code;
    logic [15:0]       commit_cnt;
    logic [2:0]        dbg_state;

    track_para_loader #(
        .TAP_NUM    (TAP_NUM),
        .ADDR_W     (ADDR_W),
        .FLUSH_IDLE (16)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .load_en_i              (load_en),
        .track_para_ren_o       (ren),
        .track_para_vld_i       (vld),
        .track_para_data_i      (data),
        .track_para_burst_end_i (be),
        .tap_rd_addr_i          (rd_addr),
        .tap_rd_data_o          (rd_data),
        .tap_valid_o            (tap_valid),
        .tap_bank_o             (tap_bank),
        .tap_update_o           (tap_update),
        .load_busy_o            (busy),
        .load_err_o             (load_err),
        .err_code_o             (err_code),
        .commit_cnt_o           (commit_cnt),
        .dbg_state_o            (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt = 0;
    int err_cnt = 0;

    // Reference model: bank contents and status at burst granularity.
    logic [31:0] words [TAP_NUM+8];
    logic [31:0] m_mem [2][TAP_NUM];
    logic        m_bank = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    logic [1:0]  m_err = 2'd0;
    logic        m_valid = 1'b0;
    int          e_upd = 0;
    int          e_errp = 0;
    logic [31:0] exp_q [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (tap_update === 1'b1) upd_cnt++;
            if (load_err === 1'b1) err_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_burst(input int n);
        if (n == TAP_NUM) begin
            m_bank = ~m_bank;
            for (int i = 0; i < TAP_NUM; i++) m_mem[m_bank][i] = words[i];
            m_cnt   = m_cnt + 16'd1;
            m_err   = 2'd0;
            m_valid = 1'b1;
            e_upd   = 1;
            e_errp  = 0;
        end else begin
            m_err  = (n < TAP_NUM) ? 2'd1 : 2'd2;
            e_upd  = 0;
            e_errp = 1;
        end
    endtask

    task automatic send_burst(input int n, input bit simul, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                vld = 1'b0;
                be  = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            vld  = 1'b1;
            data = words[i];
            be   = simul && (i == n - 1);
            @(negedge clk);
        end
        vld  = 1'b0;
        data = 32'd0;
        if (!simul) begin
            be = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            be = 1'b1;
            @(negedge clk);
        end
        be = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", {31'd0, k < 60}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_model();
        chk("bank", {31'd0, tap_bank}, {31'd0, m_bank});
        chk("err_code", {30'd0, err_code}, {30'd0, m_err});
        chk("commit_cnt", {16'd0, commit_cnt}, {16'd0, m_cnt});
        chk("tap_valid", {31'd0, tap_valid}, {31'd0, m_valid});
        chk("update_pulses", upd_cnt, e_upd);
        chk("err_pulses", err_cnt, e_errp);
    endtask

    task automatic read_check(input int a);
        rd_addr = a[ADDR_W-1:0];
        exp_q.push_back(m_mem[m_bank][a]);
        @(negedge clk);
        chk("rd_data", rd_data, exp_q.pop_front());
    endtask

    task automatic run_burst(input int n, input bit simul, input bit gaps);
        upd_cnt = 0;
        err_cnt = 0;
        send_burst(n, simul, gaps);
        model_burst(n);
        wait_idle();
        check_model();
    endtask

    typedef struct {
        int          n;
        bit          simul;
        logic [31:0] base;
        logic        exp_bank;
        logic [1:0]  exp_err;
        logic [15:0] exp_cnt;
        int          exp_upd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit found;
        logic prev_bank;
        vecs[0] = '{128, 1'b0, 32'h0000, 1'b1, 2'd0, 16'd1, 1};
        vecs[1] = '{100, 1'b0, 32'h0050, 1'b1, 2'd1, 16'd1, 0};
        vecs[2] = '{128, 1'b0, 32'h0100, 1'b0, 2'd0, 16'd2, 1};
        vecs[3] = '{130, 1'b0, 32'h0180, 1'b0, 2'd2, 16'd2, 0};
        vecs[4] = '{128, 1'b1, 32'h0200, 1'b1, 2'd0, 16'd3, 1};
        vecs[5] = '{127, 1'b1, 32'h0280, 1'b1, 2'd1, 16'd3, 0};
        vecs[6] = '{129, 1'b1, 32'h02C0, 1'b1, 2'd2, 16'd3, 0};
        vecs[7] = '{128, 1'b0, 32'h0300, 1'b0, 2'd0, 16'd4, 1};

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_ren", {31'd0, ren}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_valid", {31'd0, tap_valid}, 32'd0);
        chk("rst_bank", {31'd0, tap_bank}, 32'd0);
        chk("rst_update", {31'd0, tap_update}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_load_err", {31'd0, load_err}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        chk("rst_commit_cnt", {16'd0, commit_cnt}, 32'd0);
        rst = 1'b0;
        load_en = 1'b1;
        @(negedge clk);
        chk("ren_enabled", {31'd0, ren}, 32'd1);
        load_en = 1'b0;
        @(negedge clk);
        chk("ren_disabled", {31'd0, ren}, 32'd0);
        load_en = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < vecs[v].n; i++) words[i] = vecs[v].base + i;
            run_burst(vecs[v].n, vecs[v].simul, 1'b0);
            chk("tbl_bank", {31'd0, tap_bank}, {31'd0, vecs[v].exp_bank});
            chk("tbl_err_code", {30'd0, err_code}, {30'd0, vecs[v].exp_err});
            chk("tbl_commit_cnt", {16'd0, commit_cnt}, {16'd0, vecs[v].exp_cnt});
            chk("tbl_updates", upd_cnt, vecs[v].exp_upd);
            read_check(5);
            read_check(int'($urandom_range(0, TAP_NUM - 1)));
        end

        // Overflow: error on word 129, idle again 16 cycles after burst end.
        upd_cnt = 0;
        err_cnt = 0;
        for (int i = 0; i < 130; i++) words[i] = 32'hB000 + i;
        for (int i = 0; i < 130; i++) begin
            vld  = 1'b1;
            data = words[i];
            @(negedge clk);
            if (i == 128) begin
                chk("ovf_err_code", {30'd0, err_code}, 32'd2);
                chk("ovf_err_pulse", {31'd0, load_err}, 32'd1);
            end
        end
        vld = 1'b0;
        be  = 1'b1;
        @(negedge clk);
        be = 1'b0;
        repeat (14) @(negedge clk);
        chk("ovf_busy_15", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("ovf_busy_16", {31'd0, busy}, 32'd0);
        model_burst(130);
        repeat (2) @(negedge clk);
        check_model();

        // Last word and burst end together.
        upd_cnt = 0;
        err_cnt = 0;
        prev_bank = tap_bank;
        for (int i = 0; i < TAP_NUM; i++) words[i] = 32'hC0DE0000 + i;
        for (int i = 0; i < TAP_NUM; i++) begin
            vld  = 1'b1;
            data = words[i];
            be   = (i == TAP_NUM - 1);
            @(negedge clk);
        end
        vld = 1'b0;
        be  = 1'b0;
        chk("sim_state_commit", {29'd0, dbg_state}, {29'd0, ST_COMMIT});
        chk("sim_no_update_yet", {31'd0, tap_update}, 32'd0);
        @(negedge clk);
        chk("sim_update", {31'd0, tap_update}, 32'd1);
        chk("sim_bank", {31'd0, tap_bank}, {31'd0, ~prev_bank});
        model_burst(TAP_NUM);
        wait_idle();
        check_model();

        // Bank swap with the read address held at 3.
        for (int i = 0; i < TAP_NUM; i++) words[i] = i;
        run_burst(TAP_NUM, 1'b0, 1'b0);
        rd_addr = 3;
        for (int i = 0; i < TAP_NUM; i++) words[i] = 32'h9000 + i;
        words[3] = 32'h1234;
        upd_cnt = 0;
        err_cnt = 0;
        send_burst(TAP_NUM, 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            if (tap_update) begin
                found = 1'b1;
                chk("swap_old_data", rd_data, 32'h3);
                @(negedge clk);
                chk("swap_new_data", rd_data, 32'h1234);
            end else begin
                @(negedge clk);
            end
        end
        chk("swap_update_seen", {31'd0, found}, 32'd1);
        model_burst(TAP_NUM);
        wait_idle();
        check_model();

        // Reset in the middle of a burst.
        for (int i = 0; i < 60; i++) words[i] = 32'hDEAD0000 + i;
        for (int i = 0; i < 60; i++) begin
            vld  = 1'b1;
            data = words[i];
            @(negedge clk);
        end
        vld = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_bank  = 1'b0;
        m_cnt   = 16'd0;
        m_err   = 2'd0;
        m_valid = 1'b0;
        chk("mrst_bank", {31'd0, tap_bank}, 32'd0);
        chk("mrst_cnt", {16'd0, commit_cnt}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_valid", {31'd0, tap_valid}, 32'd0);
        for (int i = 0; i < TAP_NUM; i++) words[i] = 32'hA5000000 + i;
        run_burst(TAP_NUM, 1'b0, 1'b0);
        chk("mrst_new_bank", {31'd0, tap_bank}, 32'd1);
        chk("mrst_new_cnt", {16'd0, commit_cnt}, 32'd1);
        read_check(0);
        read_check(77);
        read_check(TAP_NUM - 1);

        // Random bursts against the model.
        for (int b = 0; b < 12; b++) begin
            int r;
            int n;
            r = $urandom_range(0, 9);
            if (r < 5) n = TAP_NUM;
            else if (r < 7) n = $urandom_range(1, TAP_NUM - 1);
            else if (r < 9) n = $urandom_range(TAP_NUM + 1, TAP_NUM + 3);
            else n = TAP_NUM;
            for (int i = 0; i < n; i++) words[i] = $urandom;
            run_burst(n, 1'(($urandom_range(0, 1))), 1'b1);
            if (m_valid) begin
                for (int j = 0; j < 3; j++) read_check(int'($urandom_range(0, TAP_NUM - 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
